sw3_serial_adder: RTL and testbench
===================================

# sw3_serial_adder

Parametrised bit-serial adder, the sequential successor to the two-input half adder cell. It adds two WIDTH-bit operands plus a carry-in, one bit per clock (LSB first), through a single full-adder slice with a registered carry. It sits beside the combinational adder cells as the area-minimal arithmetic option, with a start/busy/done handshake toward its controller or testbench generator.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (legal range ≥ 2)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when idle or done
- a  input  WIDTH  operand A; captured on accept edge
- b  input  WIDTH  operand B; captured on accept edge
- cin  input  1  carry-in; captured on accept edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; held until next accept
- cout  output  1  carry out of bit WIDTH-1; held until next accept
- sub  input  1  present only with SW3_SUB_EN; captured on accept edge

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge, the block latches a, b, cin (and sub) into shift registers, clears the bit counter, and goes to RUN.
- RUN: busy=1. Each edge computes s = a_sh[0]^b_sh[0]^c and c' = majority(a_sh[0], b_sh[0], c).
  - s is shifted into the MSB of the sum shift register; a_sh and b_sh shift right; the carry register becomes c'.
  - The counter increments. On the edge that processes bit WIDTH-1, the block goes to DONE.
- DONE: busy=0, done=1 for exactly one cycle. sum and cout are valid.
  - If start=1 at this edge, the block accepts new operands and goes to RUN (back-to-back).
  - Otherwise it goes to IDLE. sum and cout keep their values until the next accept.
- start while in RUN is ignored. It is not queued.
- Arithmetic is modulo 2^WIDTH, with the carry out of the MSB on cout. Counter width is clog2(WIDTH).
- Operand inputs are don't-care outside the accept edge.

## Timing
- Reset (rst=1 at any edge, including mid-RUN) sets state=IDLE, busy=0, done=0, sum=0, cout=0, and clears the carry, counter and shift registers. Any in-flight operation is discarded.
- rst has priority over start.
- Accept at edge k. Edges k+1 through k+WIDTH process bits 0 through WIDTH-1.
  - busy is high in the WIDTH cycles following edges k through k+WIDTH-1.
  - done is high in the cycle following edge k+WIDTH.
- Latency is WIDTH cycles from the accept edge to done.
- Back-to-back throughput is one result every WIDTH+1 cycles (start held high continuously).
- sum and cout are stable during RUN: they update only on the transition into DONE. The shift register is internal, and the outputs are registered copies.

## Configuration
- SW3_SUB_EN defined:
  - The sub port exists.
  - When sub=1 is captured, the block computes a + ~b + 1; cin is ignored and the carry register is preset to 1.
  - cout=1 means no borrow (a ≥ b, unsigned).
  - When sub=0, behaviour is identical to add.
- SW3_SUB_EN undefined: no sub port, add-only logic, and no extra state.

## Test plan
- Reset then add, WIDTH=8: a=0x00, b=0x00, cin=0, start pulse → busy for 8 cycles, done at accept+8, sum=0x00, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0x5A, b=0x3C, cin=1 → sum=0x97, cout=0.
- Start during RUN: second start with a=0x11 issued 3 cycles after accept of 0x01+0x01 → ignored; only one done, sum=0x02.
- Back-to-back: start held high with operands 0x10+0x20, then 0x7F+0x01 presented in the DONE cycle → done pulses 9 cycles apart, sums 0x30 then 0x80.
- Reset mid-operation: rst=1 at accept+4 → next cycle busy=0, done=0, sum=0x00, cout=0; a fresh start then completes normally.
- With SW3_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1; sub=1, a=0x01, b=0x02 → sum=0xFF, cout=0.

Source files
------------

// File: rtl/sw3_serial_adder.sv
// Bit-serial adder: one full-adder slice with a registered carry, LSB first, start/busy/done handshake.
// Optional subtract mode (a + ~b + 1) is built when the SW3_SUB_EN macro is defined.
module sw3_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SW3_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_RUN   = 2'd1;
  localparam logic [1:0]    ST_DONE  = 2'd2;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             s_s;
  logic             c_next_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;

  // Full-adder slice on the current LSBs and the carry register.
  always_comb begin
    s_s      = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    c_next_s = (a_sh_r[0] & b_sh_r[0]) | (a_sh_r[0] & carry_r) | (b_sh_r[0] & carry_r);
  end

  // Operand preprocessing at accept: subtraction inverts b and presets the carry.
  always_comb begin
    b_load_s = b;
    c_load_s = cin;
`ifdef SW3_SUB_EN
    if (sub) begin
      b_load_s = ~b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = b;
      c_load_s = cin;
    end
`endif
  end

  // Control FSM and datapath; sum/cout are updated only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b_load_s;
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= c_load_s;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          sum_sh_r <= {s_s, sum_sh_r[WIDTH-1:1]};
          carry_r  <= c_next_s;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_BIT) begin
            sum_r   <= {s_s, sum_sh_r[WIDTH-1:1]};
            cout_r  <= c_next_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_sw3_serial_adder.sv
// Directed self-checking bench for sw3_serial_adder (WIDTH=8); subtract vectors run when SW3_SUB_EN is defined.
module tb_sw3_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SW3_SUB_EN
  logic       sub;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int total;
  int bad;

  sw3_serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SW3_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one accept edge; returns at the falling edge right after it.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    @(negedge clk);
    a = av;
    b = bv;
    cin = cv;
`ifdef SW3_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: subtract request ignored in add-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
  endtask

  // Count falling edges until done, bounded; busy must stay high until then.
  task automatic wait_done(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (!done && n < 40) begin
      if (!busy) busy_low++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv, input logic [7:0] es, input logic ec);
    int n;
    int bl;
    launch(av, bv, cv, sv);
    wait_done(n, bl);
    check_val({tag, "_lat"}, n, 8);
    check_val({tag, "_busy"}, bl, 0);
    check_val({tag, "_sum"}, sum, es);
    check_val({tag, "_cout"}, cout, ec);
    check_val({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, done, 1'b0);
    check_val({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    int n;
    int bl;
    int extra;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
`ifdef SW3_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_sum", sum, 8'h00);
    check_val("rst_cout", cout, 1'b0);
    rst = 1'b0;

    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op("ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("cin", 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0);

    // start pulse at accept+3 must be ignored
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("run_sum_stable", sum, 8'h97);
    a = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'h00;
    wait_done(n, bl);
    check_val("ign_lat", n, 5);
    check_val("ign_sum", sum, 8'h02);
    check_val("ign_cout", cout, 1'b0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_val("ign_one_done", extra, 0);

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a = 8'h7F;
    b = 8'h01;
    wait_done(n, bl);
    check_val("b2b_lat1", n, 8);
    check_val("b2b_sum1", sum, 8'h30);
    check_val("b2b_cout1", cout, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check_val("b2b_busy_again", busy, 1'b1);
    wait_done(n, bl);
    check_val("b2b_gap", n + 1, 9);
    check_val("b2b_sum2", sum, 8'h80);
    check_val("b2b_cout2", cout, 1'b0);
    @(negedge clk);

    // reset at accept+4 discards the operation
    launch(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_done", done, 1'b0);
    check_val("mid_rst_sum", sum, 8'h00);
    check_val("mid_rst_cout", cout, 1'b0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_val("mid_rst_no_done", extra, 0);
    run_op("fresh", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
    run_op("max", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

`ifdef SW3_SUB_EN
    run_op("sub_pos", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_neg", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_op("sub_off", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
